// File: rtl/dft_scan_dump_unit.sv
// dft_scan_dump_unit: rotates one scan chain through loopback and packs the shifted-out bits into words
module dft_scan_dump_unit #(
  parameter int p_chain_len = 64,
  parameter int p_word_width = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    val_op,
  output logic                    op_ack,
  output logic                    op_commit,
  input  logic                    commit_ack,
  output logic                    output_strobe,
  output logic [p_word_width-1:0] output_data,
  output logic                    chain_se,
  output logic                    chain_si,
  input  logic                    chain_so
);
  localparam int cw = $clog2(p_chain_len + 1);
  localparam int pw = $clog2(p_word_width);
  typedef enum logic [2:0] {IDLE, ACK, SHIFT, FLUSH, COMMIT, RELEASE} state_t;
  state_t state;
  logic [cw-1:0] bit_cnt;
  logic [pw-1:0] word_pos;
  logic [p_word_width-1:0] pack, pack_nxt;
  logic last, emit;
  assign chain_si = chain_so;
  assign last = bit_cnt == cw'(p_chain_len - 1);
  assign emit = last || word_pos == pw'(p_word_width - 1);
  assign pack_nxt = pack | (p_word_width'(chain_so) << word_pos);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op_ack <= 1'b0;
      op_commit <= 1'b0;
      output_strobe <= 1'b0;
      output_data <= '0;
      chain_se <= 1'b0;
      bit_cnt <= '0;
      word_pos <= '0;
      pack <= '0;
    end else begin
      output_strobe <= 1'b0;
      case (state)
        IDLE: if (val_op) begin
          state <= ACK;
          op_ack <= 1'b1;
        end
        ACK: if (!val_op) begin
          state <= SHIFT;
          op_ack <= 1'b0;
          chain_se <= 1'b1;
          bit_cnt <= '0;
          word_pos <= '0;
          pack <= '0;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + cw'(1);
          word_pos <= word_pos + pw'(1);
          pack <= emit ? '0 : pack_nxt;
          if (emit) begin
            output_strobe <= 1'b1;
            output_data <= pack_nxt;
          end
          if (last) begin
            state <= FLUSH;
            chain_se <= 1'b0;
          end
        end
        // the final strobe is on the output during FLUSH, so commit lands a cycle after it
        FLUSH: begin
          state <= COMMIT;
          op_commit <= 1'b1;
        end
        COMMIT: if (commit_ack) begin
          state <= RELEASE;
          op_commit <= 1'b0;
        end
        RELEASE: if (!commit_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dft_scan_dump_unit.sv
// tb_dft_scan_dump_unit: three chain lengths (64, 40, 1), each DUT driving a behavioural scan chain
module tb_dft_scan_dump_unit;
  localparam int NI = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic val_op [NI], commit_ack [NI], op_ack [NI], op_commit [NI];
  logic strobe [NI], se [NI], si [NI], so [NI], ld_en [NI];
  logic [31:0] od [NI];
  logic [63:0] chain [NI];
  logic [63:0] ld_val;
  int tests = 0, fails = 0;

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int L = (g == 0) ? 64 : (g == 1) ? 40 : 1;
    dft_scan_dump_unit #(.p_chain_len(L)) dut (
      .clk(clk), .reset(reset), .val_op(val_op[g]), .op_ack(op_ack[g]),
      .op_commit(op_commit[g]), .commit_ack(commit_ack[g]), .output_strobe(strobe[g]),
      .output_data(od[g]), .chain_se(se[g]), .chain_si(si[g]), .chain_so(so[g]));
    assign so[g] = chain[g][0];
    always @(posedge clk)
      if (ld_en[g]) chain[g] <= ld_val;
      else if (se[g]) chain[g] <= (chain[g] >> 1) | (64'(si[g]) << (L - 1));
  end

  function automatic int len_of(input int g);
    return g == 0 ? 64 : g == 1 ? 40 : 1;
  endfunction

  function automatic logic [63:0] mask_of(input int n);
    return n >= 64 ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] c, input int n, input int k);
    return 32'((c & mask_of(n)) >> (32 * k));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int g, input logic [63:0] c);
    ld_val = c;
    ld_en[g] = 1'b1;
    @(negedge clk);
    ld_en[g] = 1'b0;
  endtask

  task automatic run_dump(input int g, input logic [63:0] c, input bit ld, input int hold,
                          input int ack_hold, input bit reassert,
                          output logic [31:0] w0, output logic [31:0] w1);
    int n, nse, ls, cm, nw, d;
    bit ok;
    n = len_of(g);
    nse = 0; ls = -1; cm = -1; nw = 0; ok = 1;
    w0 = '0; w1 = '0;
    if (ld) load(g, c);
    val_op[g] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!op_ack[g] || se[g]) ok = 0;
    end
    check($sformatf("ack_level_g%0d", g), 64'(ok), 64'd1);
    val_op[g] = 1'b0;
    for (int i = 1; i <= n + 10 && cm < 0; i++) begin
      @(negedge clk);
      if (i == 1) check($sformatf("ack_drop_g%0d", g), 64'(op_ack[g]), 64'd0);
      if (se[g]) nse++;
      if (strobe[g]) begin
        check($sformatf("word%0d_g%0d", nw, g), 64'(od[g]), 64'(exp_word(c, n, nw)));
        if (nw == 0) w0 = od[g]; else w1 = od[g];
        nw++;
        ls = i;
      end
      if (op_commit[g]) cm = i;
    end
    check($sformatf("se_cycles_g%0d", g), 64'(nse), 64'(n));
    check($sformatf("word_count_g%0d", g), 64'(nw), 64'((n + 31) / 32));
    check($sformatf("last_strobe_cycle_g%0d", g), 64'(ls), 64'(n + 1));
    check($sformatf("commit_cycle_g%0d", g), 64'(cm), 64'(n + 2));
    check($sformatf("chain_restored_g%0d", g), chain[g], c & mask_of(n));
    d = $urandom_range(0, 3);
    ok = 1;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      if (!op_commit[g] || strobe[g]) ok = 0;
    end
    check($sformatf("commit_held_g%0d", g), 64'(ok), 64'd1);
    commit_ack[g] = 1'b1;
    if (reassert) val_op[g] = 1'b1;
    ok = 1;
    for (int i = 0; i < ack_hold; i++) begin
      @(negedge clk);
      if (op_commit[g] || op_ack[g] || se[g]) ok = 0;
    end
    check($sformatf("release_quiet_g%0d", g), 64'(ok), 64'd1);
    commit_ack[g] = 1'b0;
    @(negedge clk);
    check($sformatf("release_exit_g%0d", g), 64'({op_ack[g], op_commit[g], se[g]}), 64'd0);
    if (reassert) begin
      @(negedge clk);
      check($sformatf("reenter_ack_g%0d", g), 64'(op_ack[g]), 64'd1);
    end
  endtask

  typedef struct {
    int g;
    logic [63:0] c;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic [31:0] a0, a1, b0, b1;
    logic [63:0] c, rot;
    int n;
    tbl[0] = '{0, 64'hDEADBEEF_01234567, 32'h01234567, 32'hDEADBEEF};
    tbl[1] = '{1, 64'h0000005A_A5A5A5A5, 32'hA5A5A5A5, 32'h0000005A};
    tbl[2] = '{2, 64'h1, 32'h00000001, 32'h0};
    tbl[3] = '{2, 64'h0, 32'h00000000, 32'h0};
    tbl[4] = '{0, 64'h0, 32'h00000000, 32'h00000000};
    tbl[5] = '{1, 64'h000000FF_FFFFFFFF, 32'hFFFFFFFF, 32'h000000FF};
    tbl[6] = '{0, 64'h80000000_00000001, 32'h00000001, 32'h80000000};
    for (int g = 0; g < NI; g++) begin
      val_op[g] = 1'b0;
      commit_ack[g] = 1'b0;
      ld_en[g] = 1'b0;
    end
    ld_val = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++)
      check($sformatf("reset_state_g%0d", g),
            64'({op_ack[g], op_commit[g], strobe[g], se[g], od[g]}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      run_dump(tbl[i].g, tbl[i].c, 1, 2, 1, 0, a0, a1);
      check($sformatf("tbl%0d_w0", i), 64'(a0), 64'(tbl[i].w0));
      check($sformatf("tbl%0d_w1", i), 64'(a1), 64'(tbl[i].w1));
    end
    run_dump(0, 64'h0123_4567_89AB_CDEF, 1, 10, 1, 0, a0, a1);
    run_dump(0, 64'hCAFEF00D_12345678, 1, 3, 5, 1, a0, a1);
    run_dump(0, 64'hCAFEF00D_12345678, 0, 3, 2, 0, b0, b1);
    check("b2b_w0", 64'(b0), 64'(a0));
    check("b2b_w1", 64'(b1), 64'(a1));
    c = 64'hDEADBEEF_01234567;
    rot = (c >> 20) | (c << 44);
    load(0, c);
    val_op[0] = 1'b1;
    repeat (2) @(negedge clk);
    val_op[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 20; i++) begin
      @(negedge clk);
      if (se[0]) n++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("reset_mid_shift_outputs",
             64'({op_ack[0], op_commit[0], strobe[0], se[0], od[0]}), 64'd0);
    check("reset_partial_rotation", chain[0], rot);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_dump(0, rot, 0, 2, 1, 0, a0, a1);
    for (int i = 0; i < 8; i++) begin
      int g;
      g = $urandom_range(0, NI - 1);
      c = {$urandom(), $urandom()} & mask_of(len_of(g));
      run_dump(g, c, 1, $urandom_range(1, 5), $urandom_range(1, 4), 0, a0, a1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
